regfile_bist: RTL and testbench

REGFILE_BIST -- requirements
Module: regfile_bist

---
 rtl/regfile_bist_pkg.sv | 29 ++
 rtl/regfile_bist_if.sv | 32 +++
 rtl/regfile_bist_pattern.sv | 22 ++
 rtl/regfile_bist.sv | 111 +++++++++++
 tb/tb_regfile_bist.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_bist_pkg.sv
// Shared types and constants for the register-file BIST: state encoding,
// register count and address width.
package regfile_bist_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR1,
    RD1,
    WR2,
    RD2,
    FIN
  } state_t;

  // Phase order once a sweep finishes; IDLE is only left on an accepted start.
  function automatic state_t next_phase(state_t s);
    case (s)
      WR1:     return RD1;
      RD1:     return WR2;
      WR2:     return RD2;
      RD2:     return FIN;
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/regfile_bist_if.sv
// Control handshake plus register-file access bus between the BIST engine
// (master) and the host / register file under test (slave).
interface regfile_bist_if;
  import regfile_bist_pkg::*;

  logic              start;
  logic              busy;
  logic              done;
  logic              pass;
  logic [ADDR_W-1:0] fail_addr;
  logic              fail_port;
  logic              en_w;
  logic [ADDR_W-1:0] w_add;
  logic [31:0]       d_in;
  logic [ADDR_W-1:0] read_a;
  logic [ADDR_W-1:0] read_b;
  logic [31:0]       da;
  logic [31:0]       db;

  modport master (
    input  start, da, db,
    output busy, done, pass, fail_addr, fail_port,
           en_w, w_add, d_in, read_a, read_b
  );

  modport slave (
    output start, da, db,
    input  busy, done, pass, fail_addr, fail_port,
           en_w, w_add, d_in, read_a, read_b
  );

endinterface

// File: rtl/regfile_bist_pattern.sv
// Combinational expected-value generator: SEED + STEP*a, inverted on the
// second pass, with register 0 optionally hard-wired to zero.
module regfile_bist_pattern
  import regfile_bist_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_0005,
  parameter logic [31:0] STEP = 32'h0000_0005
) (
  input  logic [ADDR_W-1:0] a,
  input  logic              pass,
  input  logic              r0_zero,
  output logic [31:0]       expected
);

  logic [31:0] base;

  assign base = SEED + STEP * 32'(a);

  // The zero register stays zero in both passes, so it is never inverted.
  assign expected = (r0_zero && (a == '0)) ? 32'h0 : (pass ? ~base : base);

endmodule

// File: rtl/regfile_bist.sv
// Two-pass march BIST for a 32-entry dual-read register file: write pattern,
// read back on both ports, repeat with the inverted pattern.
module regfile_bist
  import regfile_bist_pkg::*;
#(
  parameter logic [31:0] SEED    = 32'h0000_0005,
  parameter logic [31:0] STEP    = 32'h0000_0005,
  parameter bit          R0_ZERO = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  regfile_bist_if.master bus
);

  state_t            state;
  logic [ADDR_W-1:0] a;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic [ADDR_W-1:0] fail_addr_q;
  logic              fail_port_q;

  logic              in_wr;
  logic              in_rd;
  logic              second;
  logic [ADDR_W-1:0] addr_b;
  logic [31:0]       exp_a;
  logic [31:0]       exp_b;
  logic              mis_a;
  logic              mis_b;

  assign in_wr  = (state == WR1) || (state == WR2);
  assign in_rd  = (state == RD1) || (state == RD2);
  assign second = (state == WR2) || (state == RD2);
  assign addr_b = LAST_ADDR - a;

  regfile_bist_pattern #(.SEED(SEED), .STEP(STEP)) u_pattern_a (
    .a        (a),
    .pass     (second),
    .r0_zero  (R0_ZERO),
    .expected (exp_a)
  );

  regfile_bist_pattern #(.SEED(SEED), .STEP(STEP)) u_pattern_b (
    .a        (addr_b),
    .pass     (second),
    .r0_zero  (R0_ZERO),
    .expected (exp_b)
  );

  assign mis_a = in_rd && (bus.da != exp_a);
  assign mis_b = in_rd && (bus.db != exp_b);

  // pass_q doubles as the "no failure seen yet" flag, so only the first
  // mismatch of a run is latched; port A wins a same-cycle tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      a           <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_port_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state       <= WR1;
            a           <= '0;
            busy_q      <= 1'b1;
            pass_q      <= 1'b1;
            fail_addr_q <= '0;
            fail_port_q <= 1'b0;
          end
        end
        WR1, RD1, WR2, RD2: begin
          if (pass_q && (mis_a || mis_b)) begin
            pass_q      <= 1'b0;
            fail_addr_q <= mis_a ? a : addr_b;
            fail_port_q <= ~mis_a;
          end
          a <= a + 1'b1;
          if (a == LAST_ADDR) begin
            state <= next_phase(state);
            if (state == RD2) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail_addr = fail_addr_q;
  assign bus.fail_port = fail_port_q;
  assign bus.en_w      = in_wr;
  assign bus.w_add     = in_wr ? a : '0;
  assign bus.d_in      = in_wr ? exp_a : 32'h0;
  assign bus.read_a    = in_rd ? a : '0;
  assign bus.read_b    = in_rd ? addr_b : '0;

endmodule

// File: tb/tb_regfile_bist.sv
// Directed bench: behavioural register file with stuck-at-1 injection around
// the BIST, plus a second instance exercising pattern wrap-around.
module tb_regfile_bist;
  import regfile_bist_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_bist_if bus ();
  regfile_bist_if bus2 ();

  regfile_bist dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  regfile_bist #(.SEED(32'hFFFF_FFFF), .STEP(32'h0000_0001), .R0_ZERO(1'b1)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.master)
  );

  logic [31:0] regs  [32];
  logic [31:0] regs2 [32];
  logic [31:0] stuck [32];

  always @(posedge clk) if (bus.en_w) regs[bus.w_add] <= bus.d_in;
  always @(posedge clk) if (bus2.en_w) regs2[bus2.w_add] <= bus2.d_in;

  // Register 0 is hard-wired to zero; stuck bits force ones on reads.
  always_comb begin
    bus.da  = (bus.read_a == 5'd0) ? 32'h0 : (regs[bus.read_a] | stuck[bus.read_a]);
    bus.db  = (bus.read_b == 5'd0) ? 32'h0 : (regs[bus.read_b] | stuck[bus.read_b]);
    bus2.da = (bus2.read_a == 5'd0) ? 32'h0 : regs2[bus2.read_a];
    bus2.db = (bus2.read_b == 5'd0) ? 32'h0 : regs2[bus2.read_b];
  end

  int vectors = 0;
  int miscompares = 0;

  logic        busy_log  [0:140];
  logic        done_log  [0:140];
  logic        en_w_log  [0:140];
  logic [4:0]  w_add_log [0:140];
  logic [31:0] d_in_log  [0:140];
  logic [4:0]  read_a_log[0:140];
  logic [4:0]  read_b_log[0:140];
  int busy_cnt, done_cnt, done_cyc;

  task automatic clear_stuck();
    for (int i = 0; i < 32; i++) stuck[i] = 32'h0;
  endtask

  task automatic tally();
    busy_cnt = 0; done_cnt = 0; done_cyc = -1;
    for (int c = 1; c <= 140; c++) begin
      if (busy_log[c] === 1'b1) busy_cnt++;
      if (done_log[c] === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
    end
  endtask

  // Cycle 1 is the first cycle after the edge that accepts start.
  task automatic do_run(input bit poke_start);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int c = 1; c <= 140; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      busy_log[c]   = bus.busy;
      done_log[c]   = bus.done;
      en_w_log[c]   = bus.en_w;
      w_add_log[c]  = bus.w_add;
      d_in_log[c]   = bus.d_in;
      read_a_log[c] = bus.read_a;
      read_b_log[c] = bus.read_b;
      if (poke_start) bus.start = (c == 50) || (c == 129);
    end
    bus.start = 1'b0;
    tally();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    vectors++;
    if ({bus.busy, bus.done, bus.pass, bus.en_w, bus.fail_port} !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got %b, want 00000",
               {bus.busy, bus.done, bus.pass, bus.en_w, bus.fail_port});
    end
    vectors++;
    if ({bus.fail_addr, bus.w_add, bus.read_a, bus.read_b} !== 20'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_addrs: got %h, want 00000",
               {bus.fail_addr, bus.w_add, bus.read_a, bus.read_b});
    end
    vectors++;
    if (bus.d_in !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_d_in: got %h, want 00000000", bus.d_in);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_clean_run();
    clear_stuck();
    do_run(1'b0);
    vectors++;
    if (busy_cnt != 128 || busy_log[1] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL clean_busy: got %0d cycles (c1=%b), want 128 (c1=1)", busy_cnt, busy_log[1]);
    end
    vectors++;
    if (done_cyc != 129 || done_cnt != 1) begin
      miscompares++;
      $display("[TB] FAIL clean_done: got cycle %0d count %0d, want cycle 129 count 1", done_cyc, done_cnt);
    end
    vectors++;
    if (bus.pass !== 1'b1 || bus.fail_addr !== 5'd0 || bus.fail_port !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL clean_result: got pass=%b addr=%0d port=%b, want pass=1 addr=0 port=0",
               bus.pass, bus.fail_addr, bus.fail_port);
    end
    vectors++;
    if (en_w_log[8] !== 1'b1 || w_add_log[8] !== 5'd7 || d_in_log[8] !== 32'h28) begin
      miscompares++;
      $display("[TB] FAIL wr1_reg7: got en=%b addr=%0d data=%h, want en=1 addr=7 data=00000028",
               en_w_log[8], w_add_log[8], d_in_log[8]);
    end
    vectors++;
    if (d_in_log[1] !== 32'h0 || d_in_log[72] !== 32'hFFFF_FFD7 || w_add_log[72] !== 5'd7) begin
      miscompares++;
      $display("[TB] FAIL wr_patterns: got r0=%h wr2_r7=%h @%0d, want r0=00000000 wr2_r7=ffffffd7 @7",
               d_in_log[1], d_in_log[72], w_add_log[72]);
    end
    vectors++;
    if (read_a_log[33] !== 5'd0 || read_b_log[33] !== 5'd31 || en_w_log[33] !== 1'b0 ||
        read_a_log[10] !== 5'd0 || w_add_log[40] !== 5'd0) begin
      miscompares++;
      $display("[TB] FAIL rd_addrs: got ra=%0d rb=%0d en=%b ra_wr=%0d wa_rd=%0d, want 0 31 0 0 0",
               read_a_log[33], read_b_log[33], en_w_log[33], read_a_log[10], w_add_log[40]);
    end
  endtask

  task automatic test_stuck_port_a();
    clear_stuck();
    stuck[12] = 32'h0000_0008;
    do_run(1'b0);
    vectors++;
    if (bus.pass !== 1'b0 || bus.fail_addr !== 5'd12 || bus.fail_port !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stuck_reg12: got pass=%b addr=%0d port=%b, want pass=0 addr=12 port=0",
               bus.pass, bus.fail_addr, bus.fail_port);
    end
    vectors++;
    if (done_cyc != 129 || busy_cnt != 128) begin
      miscompares++;
      $display("[TB] FAIL stuck_no_abort: got done@%0d busy=%0d, want done@129 busy=128", done_cyc, busy_cnt);
    end
  endtask

  task automatic test_stuck_port_b();
    clear_stuck();
    stuck[20] = 32'h0000_0002;
    do_run(1'b0);
    vectors++;
    if (bus.pass !== 1'b0 || bus.fail_addr !== 5'd20 || bus.fail_port !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL stuck_reg20: got pass=%b addr=%0d port=%b, want pass=0 addr=20 port=1",
               bus.pass, bus.fail_addr, bus.fail_port);
    end
  endtask

  task automatic test_same_cycle();
    clear_stuck();
    stuck[5]  = 32'h0000_0040;
    stuck[26] = 32'h0000_0040;
    do_run(1'b0);
    vectors++;
    if (bus.pass !== 1'b0 || bus.fail_addr !== 5'd5 || bus.fail_port !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL tie_port_a: got pass=%b addr=%0d port=%b, want pass=0 addr=5 port=0",
               bus.pass, bus.fail_addr, bus.fail_port);
    end
  endtask

  task automatic test_reset_mid_run();
    int late_done;
    int late_busy;
    clear_stuck();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int c = 2; c <= 60; c++) begin
      @(posedge clk);
      #1;
    end
    vectors++;
    if (bus.busy !== 1'b1 || bus.read_a !== 5'd27 || bus.read_b !== 5'd4 || bus.pass !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL mid_run_c60: got busy=%b ra=%0d rb=%0d pass=%b, want 1 27 4 1",
               bus.busy, bus.read_a, bus.read_b, bus.pass);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({bus.busy, bus.done, bus.pass, bus.en_w, bus.fail_port,
         bus.fail_addr, bus.w_add, bus.read_a, bus.read_b, bus.d_in} !== 57'h0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got busy=%b pass=%b ra=%0d rb=%0d d_in=%h, want all zero",
               bus.busy, bus.pass, bus.read_a, bus.read_b, bus.d_in);
    end
    @(negedge clk);
    rst = 1'b0;
    late_done = 0;
    late_busy = 0;
    for (int c = 0; c < 140; c++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) late_done++;
      if (bus.busy === 1'b1) late_busy++;
    end
    vectors++;
    if (late_done != 0 || late_busy != 0) begin
      miscompares++;
      $display("[TB] FAIL abandoned_run: got done=%0d busy=%0d, want 0 0", late_done, late_busy);
    end
    do_run(1'b0);
    vectors++;
    if (busy_cnt != 128 || done_cyc != 129 || bus.pass !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rerun_after_reset: got busy=%0d done@%0d pass=%b, want 128 129 1",
               busy_cnt, done_cyc, bus.pass);
    end
  endtask

  task automatic test_start_ignored();
    clear_stuck();
    do_run(1'b1);
    vectors++;
    if (busy_cnt != 128 || done_cnt != 1 || done_cyc != 129 || busy_log[131] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL start_ignored: got busy=%0d done=%0d@%0d c131=%b, want 128 1@129 0",
               busy_cnt, done_cnt, done_cyc, busy_log[131]);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] r1_wr1, r2_wr1, r1_wr2;
    logic [4:0]  a1;
    int          done2_cyc;
    done2_cyc = -1;
    r1_wr1 = 32'hDEAD_BEEF;
    r2_wr1 = 32'hDEAD_BEEF;
    r1_wr2 = 32'hDEAD_BEEF;
    a1 = 5'd0;
    @(negedge clk);
    bus2.start = 1'b1;
    @(posedge clk);
    #1;
    bus2.start = 1'b0;
    for (int c = 1; c <= 140; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      if (c == 2) begin
        r1_wr1 = bus2.d_in;
        a1 = bus2.w_add;
      end
      if (c == 3) r2_wr1 = bus2.d_in;
      if (c == 66) r1_wr2 = bus2.d_in;
      if (bus2.done === 1'b1 && done2_cyc < 0) done2_cyc = c;
    end
    vectors++;
    if (a1 !== 5'd1 || r1_wr1 !== 32'h0 || r2_wr1 !== 32'h1) begin
      miscompares++;
      $display("[TB] FAIL wrap_wr1: got addr=%0d r1=%h r2=%h, want addr=1 r1=00000000 r2=00000001",
               a1, r1_wr1, r2_wr1);
    end
    vectors++;
    if (r1_wr2 !== 32'hFFFF_FFFF || done2_cyc != 129 || bus2.pass !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL wrap_run: got wr2_r1=%h done@%0d pass=%b, want ffffffff 129 1",
               r1_wr2, done2_cyc, bus2.pass);
    end
  endtask

  initial begin
    bus.start  = 1'b0;
    bus2.start = 1'b0;
    clear_stuck();
    test_reset();
    test_clean_run();
    test_stuck_port_a();
    test_stuck_port_b();
    test_same_cycle();
    test_reset_mid_run();
    test_start_ignored();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
